// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// reset PC and the prefetch-buffer entry layout.
package if_pkg;

  localparam int IF_ADDR_W = 8;
  localparam int IF_DATA_W = 32;
  localparam logic [IF_ADDR_W-1:0] IF_RESET_PC = 8'h00;

  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch entries with flush, occupancy
// count and empty/full flags. Flush wins over push/pop in the same cycle.
module if_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               push_i,
  input  fetch_entry_t       wdata_i,
  input  logic               pop_i,
  output fetch_entry_t       rdata_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; the count gates visibility, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push_i && full_o && !pop_i && !flush_i))
    else $fatal(1, "if_fifo: push into full buffer");

  a_no_underflow : assert property (@(posedge clk) disable iff (reset)
    !(pop_i && empty_o))
    else $fatal(1, "if_fifo: pop from empty buffer");

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues credit-limited requests to a
// 1-cycle instruction memory, buffers responses and handles branch redirects.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int ADDR_W = IF_ADDR_W,
  parameter int DATA_W = IF_DATA_W,
  parameter int FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = IF_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

  logic              redirect_en;
  logic              pop;
  logic              push;
  logic              credit_ok;
  logic [CNT_W:0]    committed;
  logic [CNT_W:0]    limit;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  assign redirect_en = redirect_valid & ~reset;
  assign pop         = instr_valid & instr_ready;

  // A pop this cycle frees a slot, so it is added to the limit rather than
  // subtracted from the occupancy (keeps the arithmetic unsigned-safe).
  assign committed = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
  assign limit     = DEPTH_C + (CNT_W + 1)'(pop);
  assign credit_ok = committed < limit;

  // A response arriving in a redirect cycle belongs to the wrong path.
  assign push = inflight_q & ~redirect_en;

  // NOTE: every variable below gets a default first, so no latch can be inferred.
  always_comb begin
    imem_req      = credit_ok & ~reset;
    imem_addr     = fetch_pc_q;
    fetch_pc_d    = fetch_pc_q;
    if (redirect_en) begin
      imem_req  = 1'b1;
      imem_addr = redirect_pc;
    end
    if (imem_req) fetch_pc_d = imem_addr + 1'b1;
    inflight_d    = imem_req;
    inflight_pc_d = imem_req ? imem_addr : inflight_pc_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = inflight_pc_q;
    push_entry.instr = imem_rdata;
  end

  if_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_en),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Head fields read as zero whenever nothing valid is presented.
  assign instr_valid = ~fifo_empty;
  assign instr       = instr_valid ? head_entry.instr : '0;
  assign instr_pc    = instr_valid ? head_entry.pc    : '0;

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios followed by random
// ready/redirect/reset traffic, checked against a program-order reference model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: program order, not pipeline state.
  logic [7:0] exp_pc;     // PC decode must see next
  logic [7:0] next_addr;  // address the next sequential request must carry
  int         age;        // cycles since the last restart (reset release or redirect)
  int         stall;      // consecutive cycles with instr_ready low
  logic       rec_req;
  logic [7:0] rec_addr;

  if_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [7:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pulse reset for one cycle; outputs must clear asynchronously.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    redirect_valid = 1'b0;
    #1;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_req",   32'(imem_req),    32'd0);
    check("rst_addr",  32'(imem_addr),   32'h00);
    check("rst_pc",    32'(instr_pc),    32'h00);
    check("rst_instr", instr,            32'h0);
    @(posedge clk);
    #1;
    imem_rdata = $urandom();
    reset      = 1'b0;
    exp_pc     = 8'h00;
    next_addr  = 8'h00;
    age        = -1;
    stall      = 0;
    rec_req    = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs, update the model, then act
  // as the 1-cycle instruction memory.
  task automatic step(input bit rdy, input bit rv, input logic [7:0] rpc);
    bit exp_valid;
    @(negedge clk);
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    if (age < 1000) age++;
    stall = rdy ? 0 : stall + 1;
    exp_valid = (age >= 2);

    check("instr_valid", 32'(instr_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("instr_pc", 32'(instr_pc), 32'(exp_pc));
      check("instr",    instr,         imem_word(exp_pc));
    end

    if (rv) begin
      check("redir_req",  32'(imem_req),  32'd1);
      check("redir_addr", 32'(imem_addr), 32'(rpc));
      next_addr = rpc + 8'd1;
    end else begin
      // A retiring instruction always frees a credit; a fresh restart is empty.
      if (age == 0 || (exp_valid && rdy)) check("req_credit", 32'(imem_req), 32'd1);
      if (stall >= 3 && age >= 3)         check("req_stall",  32'(imem_req), 32'd0);
      if (imem_req) begin
        check("req_addr", 32'(imem_addr), 32'(next_addr));
        next_addr = next_addr + 8'd1;
      end
    end

    if (exp_valid && rdy) exp_pc = exp_pc + 8'd1;
    if (rv) begin
      exp_pc = rpc;
      age    = 0;
    end

    rec_req  = imem_req;
    rec_addr = imem_addr;
    @(posedge clk);
    #1;
    imem_rdata = rec_req ? imem_word(rec_addr) : $urandom();
  endtask

  initial begin
    exp_pc = 8'h00; next_addr = 8'h00; age = -1; stall = 0;
    rec_req = 1'b0; rec_addr = 8'h00;

    // Reset state and first fetches.
    repeat (2) @(posedge clk);
    do_reset();
    repeat (10) step(1'b1, 1'b0, 8'h00);

    // Backpressure: head holds, requests stop, stream resumes gap-free.
    repeat (5) step(1'b0, 1'b0, 8'h00);
    repeat (6) step(1'b1, 1'b0, 8'h00);

    // Redirect while PC 4 sits at the head and PC 5 is in flight.
    do_reset();
    repeat (6) step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h20);
    repeat (6) step(1'b1, 1'b0, 8'h00);

    // Back-to-back redirects: only the latest target survives.
    step(1'b1, 1'b1, 8'h40);
    step(1'b1, 1'b1, 8'h80);
    repeat (6) step(1'b1, 1'b0, 8'h00);

    // PC wrap past 8'hFF.
    step(1'b1, 1'b1, 8'hFE);
    repeat (6) step(1'b1, 1'b0, 8'h00);

    // Reset with a full buffer.
    repeat (4) step(1'b0, 1'b0, 8'h00);
    do_reset();
    repeat (6) step(1'b1, 1'b0, 8'h00);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, 8'($urandom()));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch front end that sits directly upstream of the decode/control/register stage of the MIPS datapath. It owns the word-addressed PC and issues requests to a 1-cycle-latency instruction memory. Returned words are buffered with their PC in a small prefetch FIFO and presented to decode through a valid/ready handshake. Taken branches from the execute side redirect the PC and flush all wrong-path work.

Parameters:
ADDR_W, 8, PC / instruction-memory word-address width (PC increments by 1 per instruction)
DATA_W, 32, instruction width
FIFO_DEPTH, 2, prefetch buffer entries (power of two, >= 2)
RESET_PC, 8'h00, PC loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  request strobe to instruction memory
imem_addr  out  ADDR_W  word address of the request
imem_rdata  in  DATA_W  instruction word, valid the cycle after imem_req
redirect_valid  in  1  one-cycle pulse: taken branch, refetch from redirect_pc
redirect_pc  in  ADDR_W  branch target (PC+1+imm[7:0], computed downstream)
instr_valid  out  1  head FIFO entry is valid
instr  out  DATA_W  head instruction word
instr_pc  out  ADDR_W  PC of head instruction
instr_ready  in  1  decode accepts head this cycle

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, FIFO empty, inflight=0. Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- pop = instr_valid & instr_ready. Head advances on the clock edge.
- Credit rule: issue allowed when count + inflight - pop < FIFO_DEPTH. imem_req = allowed & ~reset.
- Normal issue: imem_addr=fetch_pc; on issue, fetch_pc <= fetch_pc+1 (mod 2^ADDR_W, 8'hFF wraps to 8'h00). inflight <= 1 and inflight_pc <= issued address; otherwise inflight <= 0.
- Response: in the cycle after issue (inflight=1), {inflight_pc, imem_rdata} is pushed at that cycle's clock edge.
- Latency: request at cycle T, instr_valid at T+2. No bypass.
- Throughput: one instruction per cycle when instr_ready is held high (FIFO_DEPTH >= 2).
- Backpressure: with instr_ready=0, the head (instr, instr_pc) holds stable. Requests stop once credits are exhausted. No word is dropped or duplicated.
- Simultaneous push and pop on a full FIFO is legal. The credit rule guarantees a push never overflows; overflow or underflow is a fatal assertion.
- Redirect (cycle R, redirect_valid=1):
  - A pop in R still retires (the branch itself).
  - The FIFO is cleared and any response arriving in R is discarded (not pushed).
  - In R the redirect_pc request is issued combinationally: imem_addr=redirect_pc, imem_req=1 regardless of credits, since the FIFO is empty next cycle.
  - fetch_pc <= redirect_pc+1, inflight <= 1, inflight_pc <= redirect_pc.
  - instr_valid stays per current FIFO state in R, is 0 in R+1, and shows the target at R+2.
- Redirect pulses on consecutive cycles: the latest wins; each flushes the previous one's in-flight request.
- redirect_pc = 8'hFF: fetch_pc wraps to 8'h00.
- Reset asserted mid-stream: all state is lost immediately. The first request is issued in the first cycle after reset deasserts, at RESET_PC.

Decomposition:
- Shared package if_pkg: ADDR_W/DATA_W/RESET_PC defaults and the fetch-entry struct {pc[ADDR_W], instr[DATA_W]}.
- One sub-module, if_fifo: a synchronous FIFO with flush, push/pop, count and empty/full outputs, holding if_pkg entries.
- The top level holds the PC, inflight tracking, credit logic and redirect handling.

Test Plan:
- Reset release, instr_ready=1, imem returns 32'h1000_0000+addr: instr_valid at cycle 2 with instr_pc=0, instr=32'h1000_0000; then PCs 1,2,3 on consecutive cycles.
- Stream 8 instructions, then instr_ready=0 for 5 cycles: imem_req drops within 2 cycles, head holds PC n stable, and on release PCs n,n+1,... resume with no gaps or duplicates.
- Redirect to 8'h20 while PC 5 is in flight and PC 4 is at the head with ready=1: PC 4 retires; PC 5 and the FIFO are discarded; instr_valid=0 in R+1; instr_pc=8'h20 at R+2, then 8'h21.
- Back-to-back redirects to 8'h40 then 8'h80: only 8'h80, 8'h81, ... emerge; 8'h40 never appears.
- Start the stream at redirect_pc=8'hFE: PCs 8'hFE, 8'hFF, 8'h00, 8'h01 in order.
- Assert reset for 1 cycle mid-stream with a full FIFO: instr_valid=0 immediately; the next instr_pc seen is RESET_PC at 2 cycles after deassert; the overflow assertion never fires.
